// File: rtl/ram_dump_pkg.sv
// rtl/ram_dump_pkg.sv - shared types and constants for the trace-RAM dump engine
// Purpose: dump FSM state encoding and the fixed LAT->XMIT pipeline latency.
// Ports: none (package).
package ram_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_CORR,
        ST_XMIT,
        ST_WAIT
    } dump_state_t;

    // Cycles from entering LAT to the trmt strobe (LAT, CORR, XMIT).
    localparam int LAT_TO_XMIT = 3;

endpackage

// File: rtl/ram_dump_if.sv
// rtl/ram_dump_if.sv - byte transmit handshake between dump engine and UART
// Purpose: groups the trmt/tx_data/tx_done handshake.
// Signals: trmt (one-cycle strobe), tx_data (byte, held until next trmt),
//          tx_done (transmitter finished the current byte).
// Modports: master = dump engine, slave = transmitter.
interface ram_dump_if #(
    parameter int DATA_W = 8
) ();

    logic              trmt;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;

    modport master (
        output trmt,
        output tx_data,
        input  tx_done
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output tx_done
    );

endinterface

// File: rtl/ram_dump_og_correct.sv
// rtl/ram_dump_og_correct.sv - combinational offset/gain correction of one sample
// Purpose: result = sat(sat(rdata + offset) * gain >> (DATA_W-1)).
// Ports: rdata  in  DATA_W  raw sample (unsigned)
//        offset in  DATA_W  signed two's complement offset
//        gain   in  DATA_W  unsigned 1.(DATA_W-1) fixed-point gain
//        result out DATA_W  corrected sample
module og_correct #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] gain,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MAX_VAL = '1;

    logic [DATA_W+1:0]   sum;
    logic [DATA_W-1:0]   sat_sum;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     shifted;

    always_comb begin
        // Two guard bits: bit DATA_W+1 is the sign, bit DATA_W is overflow.
        sum = {2'b00, rdata} + {{2{offset[DATA_W-1]}}, offset};
        if (sum[DATA_W+1]) begin
            sat_sum = '0;
        end else if (sum[DATA_W]) begin
            sat_sum = MAX_VAL;
        end else begin
            sat_sum = sum[DATA_W-1:0];
        end

        prod    = {{DATA_W{1'b0}}, sat_sum} * {{DATA_W{1'b0}}, gain};
        // Gain of 1.0 is 2**(DATA_W-1); one extra bit catches gains above 1.0.
        shifted = (DATA_W+1)'(prod >> (DATA_W - 1));
        result  = shifted[DATA_W] ? MAX_VAL : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/ram_dump_engine.sv
// rtl/ram_dump_engine.sv - trace-RAM dump engine feeding a byte transmitter
// Purpose: forwards capture-side RAM enable/address outside a dump; on request
//          reads one channel's circular trace oldest-first (from trace_end+1),
//          corrects each sample and sends it under the trmt/tx_done handshake.
// Build option: RAM_DUMP_CORR_EN defined builds the offset/gain correction;
//          undefined sends the raw sample with identical timing.
// Ports: clk, rst (async, active-high)
//        we, cap_en, cap_addr        capture side (capture has priority)
//        trace_end                   address of the newest captured sample
//        dump_req, dump_chan         dump start pulse and channel select
//        ch_rdata, og                RAM read data and per-channel {gain, offset}
//        en, addr                    RAM enable / address
//        dump_busy/done/err          status
//        tx                          transmit handshake (master)
module ram_dump_engine
    import ram_dump_pkg::*;
#(
    parameter int  NUM_CH = 3,
    parameter int  DATA_W = 8,
    parameter int  ADDR_W = 9,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     cap_en,
    input  logic [ADDR_W-1:0]        cap_addr,
    input  logic [ADDR_W-1:0]        trace_end,
    input  logic                     dump_req,
    input  logic [CH_W-1:0]          dump_chan,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic [NUM_CH*2*DATA_W-1:0] og,
    output logic                     en,
    output logic [ADDR_W-1:0]        addr,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic                     dump_err,
    ram_dump_if.master               tx
);

    dump_state_t       state_q, state_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [DATA_W-1:0] gain_q, gain_d;
    logic [DATA_W-1:0] off_q, off_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] sel_rdata;
    logic [DATA_W-1:0] req_gain;
    logic [DATA_W-1:0] req_off;
    logic [DATA_W-1:0] corr_data;
    logic              chan_ok;

    // Channel muxes: read data by the latched channel, {gain, offset} by the
    // requested channel so they can be latched on the start cycle.
    always_comb begin
        sel_rdata = '0;
        req_gain  = '0;
        req_off   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan_q == CH_W'(i)) begin
                sel_rdata = ch_rdata[i*DATA_W +: DATA_W];
            end
            if (dump_chan == CH_W'(i)) begin
                req_off  = og[i*2*DATA_W +: DATA_W];
                req_gain = og[i*2*DATA_W+DATA_W +: DATA_W];
            end
        end
    end

    assign chan_ok = ({1'b0, dump_chan} < (CH_W+1)'(NUM_CH));

`ifdef RAM_DUMP_CORR_EN
    og_correct #(
        .DATA_W (DATA_W)
    ) u_og_correct (
        .rdata  (rdata_q),
        .offset (off_q),
        .gain   (gain_q),
        .result (corr_data)
    );
`else
    assign corr_data = rdata_q;

    logic unused_og;
    assign unused_og = ^{og, gain_q, off_q};
`endif

    always_comb begin
        state_d   = state_q;
        en_d      = 1'b0;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        gain_d    = gain_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                en_d   = cap_en;
                addr_d = cap_addr;
                if (dump_req) begin
                    if (!chan_ok) begin
                        err_d = 1'b1;
                    end else if (!we) begin
                        state_d = ST_RD;
                        en_d    = 1'b1;
                        addr_d  = trace_end + ADDR_W'(1);
                        cnt_d   = '0;
                        chan_d  = dump_chan;
                        gain_d  = req_gain;
                        off_d   = req_off;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                rdata_d = sel_rdata;
                state_d = ST_CORR;
            end
            ST_CORR: begin
                tx_data_d = corr_data;
                trmt_d    = 1'b1;
                state_d   = ST_XMIT;
            end
            ST_XMIT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx.tx_done) begin
                    if (cnt_q == '1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        en_d    = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture takes the RAM back: abandon the dump, drop any strobe that
        // was about to be issued and keep the last transmitted byte.
        if (state_q != ST_IDLE && we) begin
            state_d   = ST_IDLE;
            en_d      = cap_en;
            addr_d    = cap_addr;
            tx_data_d = tx_data_q;
            trmt_d    = 1'b0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            chan_q    <= '0;
            gain_q    <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            gain_q    <= gain_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign en         = en_q;
    assign addr       = addr_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;
    assign dump_err   = err_q;
    assign tx.trmt    = trmt_q;
    assign tx.tx_data = tx_data_q;

endmodule

// File: tb/tb_ram_dump_engine.sv
// tb/tb_ram_dump_engine.sv - directed self-checking bench for ram_dump_engine
module tb_ram_dump_engine;
    import ram_dump_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

`ifdef RAM_DUMP_CORR_EN
    localparam logic [7:0] E_OFS_HI0  = 8'hFF, E_OFS_HI1  = 8'hA7;
    localparam logic [7:0] E_OFS_LO0  = 8'h00, E_OFS_LO1  = 8'h67;
    localparam logic [7:0] E_GAIN_HI0 = 8'hFF, E_GAIN_HI1 = 8'h8D;
    localparam logic [7:0] E_GAIN_LO0 = 8'h48, E_GAIN_LO1 = 8'h23;
`else
    localparam logic [7:0] E_OFS_HI0  = 8'hF0, E_OFS_HI1  = 8'h87;
    localparam logic [7:0] E_OFS_LO0  = 8'h10, E_OFS_LO1  = 8'h87;
    localparam logic [7:0] E_GAIN_HI0 = 8'h90, E_GAIN_HI1 = 8'h47;
    localparam logic [7:0] E_GAIN_LO0 = 8'h90, E_GAIN_LO1 = 8'h47;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we;
    logic                     cap_en;
    logic [ADDR_W-1:0]        cap_addr;
    logic [ADDR_W-1:0]        trace_end;
    logic                     dump_req;
    logic [1:0]               dump_chan;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic [NUM_CH*2*DATA_W-1:0] og;
    logic                     en;
    logic [ADDR_W-1:0]        addr;
    logic                     dump_busy;
    logic                     dump_done;
    logic                     dump_err;

    ram_dump_if #(.DATA_W(DATA_W)) tx_if ();

    ram_dump_engine #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .cap_en    (cap_en),
        .cap_addr  (cap_addr),
        .trace_end (trace_end),
        .dump_req  (dump_req),
        .dump_chan (dump_chan),
        .ch_rdata  (ch_rdata),
        .og        (og),
        .en        (en),
        .addr      (addr),
        .dump_busy (dump_busy),
        .dump_done (dump_done),
        .dump_err  (dump_err),
        .tx        (tx_if.master)
    );

    always #5 clk = ~clk;

    // Capture RAMs: registered read, data valid the cycle after en.
    logic [7:0] mem [NUM_CH][DEPTH];
    always @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_rdata[c*8 +: 8] <= mem[c][addr];
            end
        end
    end

    // Transmitter: tx_done a fixed number of cycles after each trmt.
    int tx_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt         <= 0;
            tx_if.tx_done  <= 1'b0;
        end else begin
            tx_if.tx_done <= 1'b0;
            if (tx_if.trmt) begin
                tx_cnt <= 5;
            end else if (tx_cnt > 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) tx_if.tx_done <= 1'b1;
            end
        end
    end

    // Monitor
    int         trmt_cnt = 0, done_cnt = 0, err_cnt = 0;
    int         busy_at_done = 0, en_after_txd = 0;
    logic       txd_prev = 1'b0;
    logic [7:0] got_q [$];
    always @(negedge clk) begin
        if (tx_if.trmt) begin
            trmt_cnt++;
            got_q.push_back(tx_if.tx_data);
        end
        if (dump_done) begin
            done_cnt++;
            if (dump_busy) busy_at_done++;
        end
        if (dump_err) err_cnt++;
        if (txd_prev && en) en_after_txd++;
        txd_prev = tx_if.tx_done;
    end

    int n_cmp = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_og(input int c, input logic [7:0] gain, input logic [7:0] off);
        og[c*16 +: 16] = {gain, off};
    endtask

    task automatic pulse_req(input logic [1:0] chan, input logic [3:0] te);
        trace_end = te;
        dump_chan = chan;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
    endtask

    task automatic wait_trmt(input int n, input string tag);
        int k = 0;
        while (trmt_cnt < n && k < 2000) begin
            step();
            k++;
        end
        if (trmt_cnt < n) chk(tag, trmt_cnt, n);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cnt < n && k < 2000) begin
            step();
            k++;
        end
        if (done_cnt < n) chk(tag, done_cnt, n);
    endtask

    function automatic logic [31:0] outs();
        return 32'({en, addr, tx_if.trmt, tx_if.tx_data, dump_busy, dump_done, dump_err});
    endfunction

    task automatic corr_case(input string tag, input int chan, input logic [7:0] gain,
                             input logic [7:0] off, input logic [7:0] raw,
                             input logic [7:0] exp0, input logic [7:0] exp1);
        int d0;
        set_og(chan, gain, off);
        mem[chan][6] = raw;
        got_q.delete();
        d0 = done_cnt;
        pulse_req(2'(chan), 4'd5);
        wait_done(d0 + 1, {tag, "_done_wait"});
        chk({tag, "_s0"}, (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'(exp0));
        chk({tag, "_s1"}, (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'(exp1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, t0, e0, en_hi;

        rst = 1'b1; we = 1'b0; cap_en = 1'b0; cap_addr = '0; trace_end = '0;
        dump_req = 1'b0; dump_chan = '0; og = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[c][i] = (c == 1) ? 8'(i) : ((c == 0) ? 8'(8'h40 + i) : 8'(8'h80 + i));
            end
        end

        // Reset state
        step();
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b0;
        step();
        chk("post_reset_outs", outs(), 32'h0);

        // Full dump of channel 1, order, count and start timing
        set_og(1, 8'h80, 8'h00);
        got_q.delete();
        d0 = done_cnt; en_after_txd = 0; busy_at_done = 0;
        pulse_req(2'd1, 4'd5);
        chk("t1_en_c1", en, 1);
        chk("t1_addr_c1", addr, 6);
        chk("t1_busy_c1", dump_busy, 1);
        repeat (LAT_TO_XMIT - 1) step();
        chk("t1_trmt_c3", tx_if.trmt, 0);
        step();
        chk("t1_trmt_c4", tx_if.trmt, 1);
        chk("t1_data_c4", tx_if.tx_data, 6);
        wait_done(d0 + 1, "t1_done_wait");
        step();
        chk("t1_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk($sformatf("t1_data%0d", i), got_q[i], (i + 6) % 16);
        end
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_en_after_txd", en_after_txd, 15);
        chk("t1_busy_end", dump_busy, 0);

        // Offset and gain saturation
        corr_case("ofs_hi",  2, 8'h80, 8'h20, 8'hF0, E_OFS_HI0,  E_OFS_HI1);
        corr_case("ofs_lo",  2, 8'h80, 8'hE0, 8'h10, E_OFS_LO0,  E_OFS_LO1);
        corr_case("gain_hi", 0, 8'hFF, 8'h00, 8'h90, E_GAIN_HI0, E_GAIN_HI1);
        corr_case("gain_lo", 0, 8'h40, 8'h00, 8'h90, E_GAIN_LO0, E_GAIN_LO1);

        // Rejected request
        e0 = err_cnt; t0 = trmt_cnt;
        pulse_req(2'd3, 4'd5);
        chk("rej_err", dump_err, 1);
        en_hi = 0;
        repeat (10) begin
            step();
            if (en) en_hi++;
        end
        chk("rej_en", en_hi, 0);
        chk("rej_trmt", trmt_cnt - t0, 0);
        chk("rej_errcnt", err_cnt - e0, 1);
        chk("rej_busy", dump_busy, 0);

        // Capture abort after the 4th strobe
        set_og(1, 8'h80, 8'h00);
        got_q.delete();
        d0 = done_cnt; t0 = trmt_cnt;
        pulse_req(2'd1, 4'd5);
        wait_trmt(t0 + 4, "abort_wait4");
        we = 1'b1; cap_en = 1'b1; cap_addr = 4'd9;
        step();
        chk("abort_en", en, 1);
        chk("abort_addr", addr, 9);
        chk("abort_busy", dump_busy, 0);
        cap_addr = 4'd3;
        step();
        chk("abort_addr2", addr, 3);
        repeat (30) step();
        chk("abort_trmt", trmt_cnt - t0, 4);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_last", (got_q.size() > 3) ? 32'(got_q[3]) : 32'hDEAD, 9);
        we = 1'b0; cap_en = 1'b0; cap_addr = '0;
        repeat (2) step();

        // Reset during WAIT, then restart
        d0 = done_cnt; t0 = trmt_cnt;
        pulse_req(2'd1, 4'd5);
        wait_trmt(t0 + 1, "rst_wait1");
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("rst_outs", outs(), 32'h0);
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst_no_done", done_cnt - d0, 0);
        got_q.delete();
        d0 = done_cnt;
        pulse_req(2'd1, 4'd5);
        chk("rst_restart_addr", addr, 6);
        wait_done(d0 + 1, "rst_done_wait");
        chk("rst_restart_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 6);
        chk("rst_restart_count", got_q.size(), 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
